mem_port_arbiter: RTL

Shares the single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the pipelined RISC-V core. It grants one requester at a time, drives the memory port and the port-select line, and returns acknowledge and stall signals to both stages. Data accesses have priority, with an anti-starvation counter that guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_port_arbiter_starve_ctr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // Wide enough for the largest allowed starvation limit (15).
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants won while fetch was left waiting.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

    logic [STARVE_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_C)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the data stage; data has priority,
// with a starvation limit that eventually forces a fetch grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                sel
);

    arb_state_t          r_state;
    logic                r_sel;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;
    logic [DATA_W/8-1:0] r_memBe;

    logic w_done;
    logic w_ifPend;
    logic w_dPend;
    logic w_arbOpen;
    logic w_grantIf;
    logic w_grantD;
    logic w_atMax;

    assign w_done = (r_state == ARB_BUSY) && mem_ready;
    assign if_ack = w_done && (r_sel == OWNER_IF);
    assign d_ack  = w_done && (r_sel == OWNER_D);

    // A request acknowledged this cycle is consumed and may not be re-granted at this edge.
    assign w_ifPend  = if_req && !if_ack;
    assign w_dPend   = d_req && !d_ack;
    assign w_arbOpen = (r_state == ARB_IDLE) || mem_ready;
    assign w_grantIf = w_arbOpen && w_ifPend && (!w_dPend || w_atMax);
    assign w_grantD  = w_arbOpen && w_dPend && !w_grantIf;

    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_grantD && w_ifPend),
        .i_clr   (w_grantIf),
        .o_at_max(w_atMax)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_sel      <= OWNER_IF;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memBe    <= '0;
        end else if (w_grantIf) begin
            r_state    <= ARB_BUSY;
            r_sel      <= OWNER_IF;
            r_memWe    <= 1'b0;
            r_memAddr  <= if_addr;
            r_memWdata <= '0;
            r_memBe    <= '0;
        end else if (w_grantD) begin
            r_state    <= ARB_BUSY;
            r_sel      <= OWNER_D;
            r_memWe    <= d_we;
            r_memAddr  <= d_addr;
            r_memWdata <= d_wdata;
            r_memBe    <= d_be;
        end else if (w_arbOpen) begin
            r_state    <= ARB_IDLE;
        end
    end

    assign mem_req   = (r_state == ARB_BUSY);
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_be    = r_memBe;
    assign sel       = r_sel;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_stall  = if_req && !if_ack;
    assign d_stall   = d_req && !d_ack;

endmodule
